mult_seq_ctrl: RTL and testbench

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

---
 rtl/mult_seq_ctrl_if.sv | 24 ++
 rtl/mult_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_mult_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_seq_ctrl_if.sv
// Handshake and operand/result bundle for the sequential multiplier.
// The master drives the request side and the slave returns the product.
interface mult_seq_ctrl_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic             signedMode;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, signedMode, op1, op2,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, signedMode, op1, op2,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-add multiplier with a fixed latency of WIDTH+2 cycles.
// Signed operands are multiplied as magnitudes and the product is negated at the end.
//
// state | meaning
// IDLE  | waiting for start; result registers hold
// RUN   | one add/shift step per cycle, WIDTH steps
// FIN   | apply sign, load hi/lo, pulse done
module mult_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  mult_seq_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } stateT;

  stateT              state;
  stateT              nextState;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               negFlag;
  logic               busyReg;
  logic               doneReg;
  logic [WIDTH-1:0]   hiReg;
  logic [WIDTH-1:0]   loReg;

  logic               busyNext;
  logic               doneNext;
  logic               accept;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [WIDTH:0]     stepSum;
  logic [2*WIDTH-1:0] result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      state   <= nextState;
      busyReg <= busyNext;
      doneReg <= doneNext;
    end
  end

  always_comb begin
    nextState = state;
    busyNext  = busyReg;
    doneNext  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          nextState = RUN;
          busyNext  = 1'b1;
          accept    = 1'b1;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(WIDTH - 1)) begin
          nextState = FIN;
        end
      end
      FIN: begin
        nextState = IDLE;
        busyNext  = 1'b0;
        doneNext  = 1'b1;
      end
      default: begin
        nextState = IDLE;
        busyNext  = 1'b0;
      end
    endcase
  end

  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  always_comb begin
    mag1 = bus.op1;
    mag2 = bus.op2;
    if (bus.signedMode && bus.op1[WIDTH-1]) begin
      mag1 = ~bus.op1 + WIDTH'(1);
    end
    if (bus.signedMode && bus.op2[WIDTH-1]) begin
      mag2 = ~bus.op2 + WIDTH'(1);
    end
  end

  // The carry-out of the upper-half add becomes the new MSB after the shift.
  always_comb begin
    stepSum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (mplier[0]) begin
      stepSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    end
  end

  always_comb begin
    result = acc;
    if (negFlag) begin
      result = ~acc + (2*WIDTH)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      negFlag <= 1'b0;
      hiReg   <= '0;
      loReg   <= '0;
    end else if (accept) begin
      mcand   <= mag1;
      mplier  <= mag2;
      acc     <= '0;
      cnt     <= '0;
      negFlag <= bus.signedMode & (bus.op1[WIDTH-1] ^ bus.op2[WIDTH-1]);
    end else if (state == RUN) begin
      acc    <= {stepSum, acc[WIDTH-1:1]};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      cnt    <= cnt + CNT_W'(1);
    end else if (state == FIN) begin
      hiReg <= result[2*WIDTH-1:WIDTH];
      loReg <= result[WIDTH-1:0];
    end
  end

  assign bus.busy = busyReg;
  assign bus.done = doneReg;
  assign bus.hi   = hiReg;
  assign bus.lo   = loReg;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: a cycle-level reference model compared every
// cycle, plus directed corner cases and randomized operands.
module tb_mult_seq_ctrl;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  bit   chkEn;

  mult_seq_ctrl_if #(.WIDTH(32)) bus ();

  mult_seq_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] refProd(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Reference model: an operation is in flight for 33 edges after acceptance,
  // and its product appears with done on the 33rd edge after the accepting one.
  bit          mActive;
  int          mAge;
  bit          mDone;
  logic [31:0] mHi;
  logic [31:0] mLo;
  logic [63:0] mPend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mActive = 1'b0;
      mAge    = 0;
      mDone   = 1'b0;
      mHi     = '0;
      mLo     = '0;
    end else begin
      mDone = 1'b0;
      if (mActive) begin
        mAge++;
        if (mAge == 33) begin
          {mHi, mLo} = mPend;
          mDone      = 1'b1;
          mActive    = 1'b0;
        end
      end else if (bus.start) begin
        mActive = 1'b1;
        mAge    = 0;
        mPend   = refProd(bus.signedMode, bus.op1, bus.op2);
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (chkEn) begin
      tests++;
      if (bus.busy !== mActive || bus.done !== mDone || bus.hi !== mHi || bus.lo !== mLo) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t busy=%0b done=%0b hi=%h lo=%h, expected busy=%0b done=%0b hi=%h lo=%h",
                 $time, bus.busy, bus.done, bus.hi, bus.lo, mActive, mDone, mHi, mLo);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Waits for done starting right after a start was driven; returns latency in cycles (0 = timeout).
  task automatic waitDone(input bit spam, output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start      = 1'b0;
        bus.op1        = $urandom;
        bus.op2        = $urandom;
        bus.signedMode = 1'($urandom_range(0, 1));
      end else if (spam && k <= 32) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.op1   = $urandom;
        bus.op2   = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic runOp(input string nm, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] expP, input bit spam);
    int lat;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.signedMode = sgn;
    bus.op1        = a;
    bus.op2        = b;
    waitDone(spam, lat);
    chk({nm, "_latency"}, 64'(lat), 64'd34);
    chk({nm, "_product"}, {bus.hi, bus.lo}, expP);
  endtask

  initial begin
    int          lat;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    tests = 0;
    fails = 0;
    chkEn = 1'b0;
    rst_n = 1'b0;
    bus.start      = 1'b0;
    bus.signedMode = 1'b0;
    bus.op1        = '0;
    bus.op2        = '0;

    chk("model_3x3", refProd(1'b1, 32'd3, 32'd3), 64'h0000_0000_0000_0009);
    chk("model_m1x1_s", refProd(1'b1, 32'hFFFF_FFFF, 32'd1), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("model_m1x1_u", refProd(1'b0, 32'hFFFF_FFFF, 32'd1), 64'h0000_0000_FFFF_FFFF);
    chk("model_min_sq", refProd(1'b1, 32'h8000_0000, 32'h8000_0000), 64'h4000_0000_0000_0000);
    chk("model_max_m1", refProd(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFF_8000_0001);

    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {30'b0, bus.busy, bus.done, bus.hi, bus.lo}, 96'h0);
    chkEn = 1'b1;

    // First start is presented while still in reset and must be taken on the first edge after release.
    bus.start      = 1'b1;
    bus.signedMode = 1'b1;
    bus.op1        = 32'd3;
    bus.op2        = 32'd3;
    @(negedge clk);
    rst_n = 1'b1;
    waitDone(1'b0, lat);
    chk("first_after_reset_latency", 64'(lat), 64'd34);
    chk("first_after_reset_3x3", {bus.hi, bus.lo}, 64'h9);

    runOp("s_m1x1", 1'b1, 32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    runOp("u_m1x1", 1'b0, 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF, 1'b0);
    runOp("s_min_sq", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    runOp("s_max_m1", 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1'b1);
    runOp("s_0x0", 1'b1, 32'd0, 32'd0, 64'h0, 1'b0);
    runOp("u_0x0", 1'b0, 32'd0, 32'd0, 64'h0, 1'b0);
    runOp("s_0xm1", 1'b1, 32'd0, 32'hFFFF_FFFF, 64'h0, 1'b0);
    runOp("u_0xm1", 1'b0, 32'd0, 32'hFFFF_FFFF, 64'h0, 1'b0);

    // Start while busy is ignored; start in the done cycle is taken back-to-back.
    @(negedge clk);
    bus.start      = 1'b1;
    bus.signedMode = 1'b0;
    bus.op1        = 32'd2;
    bus.op2        = 32'd3;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.start = (k == 10);
      if (k == 10) begin
        bus.op1 = 32'd5;
        bus.op2 = 32'd7;
      end
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    chk("busy_start_latency", 64'(lat), 64'd34);
    chk("busy_start_ignored", {bus.hi, bus.lo}, 64'd6);
    bus.start = 1'b1;
    bus.op1   = 32'd5;
    bus.op2   = 32'd7;
    waitDone(1'b0, lat);
    chk("back_to_back_latency", 64'(lat), 64'd34);
    chk("back_to_back_5x7", {bus.hi, bus.lo}, 64'h23);

    // Reset in the middle of a run aborts it without a done pulse.
    @(negedge clk);
    bus.start      = 1'b1;
    bus.signedMode = 1'b0;
    bus.op1        = 32'hFFFF_FFFF;
    bus.op2        = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_reset_outputs", {30'b0, bus.busy, bus.done, bus.hi, bus.lo}, 96'h0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      #1;
      if (bus.done) lat = k;
    end
    chk("abort_no_done", 64'(lat), 64'd0);
    runOp("after_abort_1x1", 1'b0, 32'd1, 32'd1, 64'd1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'h0;
        default: a = $urandom;
      endcase
      b = (i % 4 == 0) ? 32'h8000_0000 : $urandom;
      runOp("random", sgn, a, b, refProd(sgn, a, b), 1'b1);
    end

    repeat (3) @(negedge clk);
    chkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
